hub75_bcm_scanner: RTL

- Parametrised HUB75 RGB matrix scan engine. Successor to main_fsm.
- Adds configurable panel width, row-address width and colour depth, plus binary-coded-modulation (BCM) brightness.
- Fetches pixel pairs (top and bottom half) from an external frame buffer with 1-cycle read latency.
- Shifts each bitplane out, latches it, then enables the display for a binary-weighted time. Sits between the frame buffer and the panel connector.

---
 rtl/hub75_bcm_scanner.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/hub75_bcm_scanner.sv
// ---------------------------------------------------------------------------
// hub75_bcm_scanner
//
// HUB75 RGB matrix scan engine with binary-coded-modulation brightness.
// For every row pair and every bitplane it fetches one pixel pair per column
// from an external frame buffer (1-cycle read latency), shifts the selected
// bitplane out on rgb0/rgb1 with a panel shift clock, blanks, latches, and
// then enables the panel for BASE_TICKS<<plane cycles.
//
// Every output is a register whose next value is computed from the state of
// the current cycle, so what is seen on the pins lags the internal state by
// exactly one cycle. A plane therefore occupies 1+2*COLS+2+(BASE_TICKS<<plane)
// cycles on the pins just as it does internally.
//
// Ports:
//   slowClk1    system clock, all logic on the rising edge
//   reset       asynchronous active-low reset
//   en          scan enable; dropping it aborts to IDLE and restarts the frame
//   rd_row      frame-buffer row address
//   rd_col      frame-buffer column address
//   rd_data0    top-half pixel {R,G,B}, valid 1 cycle after the address
//   rd_data1    bottom-half pixel, same format
//   row_out     panel row address
//   rgb0/rgb1   top/bottom serial colour bits
//   clk_out     panel shift clock
//   latch       panel latch, active-high
//   oe          panel output enable, active-low (1 = blanked)
//   frame_done  one-cycle pulse after the last plane of the last row
//   dbg_state_o current FSM state (IDLE=0 SHIFT=1 BLANK=2 LATCH=3 DISPLAY=4)
// ---------------------------------------------------------------------------
module hub75_bcm_scanner #(
    parameter int COLS       = 32,
    parameter int ROW_BITS   = 4,
    parameter int COLOR_BITS = 4,
    parameter int BASE_TICKS = 8
) (
    input  logic                    slowClk1,
    input  logic                    reset,
    input  logic                    en,
    output logic [ROW_BITS-1:0]     rd_row,
    output logic [$clog2(COLS)-1:0] rd_col,
    input  logic [3*COLOR_BITS-1:0] rd_data0,
    input  logic [3*COLOR_BITS-1:0] rd_data1,
    output logic [ROW_BITS-1:0]     row_out,
    output logic [2:0]              rgb0,
    output logic [2:0]              rgb1,
    output logic                    clk_out,
    output logic                    latch,
    output logic                    oe,
    output logic                    frame_done,
    output logic [2:0]              dbg_state_o
);

    localparam int COL_W   = $clog2(COLS);
    localparam int SHIFT_W = $clog2(2*COLS+1);
    localparam int PLANE_W = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    // Sized for the longest plane (BASE_TICKS<<(COLOR_BITS-1)) plus headroom.
    localparam int TICK_W  = $clog2(BASE_TICKS << (COLOR_BITS-1)) + 1;

    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS-1);
    localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(2*COLS);
    localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(COLOR_BITS-1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        BLANK   = 3'd2,
        LATCH   = 3'd3,
        DISPLAY = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [ROW_BITS-1:0]  row_q, row_d;
    logic [PLANE_W-1:0]   plane_q, plane_d;
    logic [SHIFT_W-1:0]   shift_cnt_q, shift_cnt_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [TICK_W-1:0]    tick_last;

    logic [ROW_BITS-1:0]  rd_row_q, rd_row_d;
    logic [COL_W-1:0]     rd_col_q, rd_col_d;
    logic [ROW_BITS-1:0]  row_out_q, row_out_d;
    logic [2:0]           rgb0_q, rgb0_d;
    logic [2:0]           rgb1_q, rgb1_d;
    logic                 clk_out_q, clk_out_d;
    logic                 latch_q, latch_d;
    logic                 oe_q, oe_d;
    logic                 frame_done_q, frame_done_d;

    // Selects bit 'pl' of each of the R, G and B fields of a packed pixel.
    function automatic logic [2:0] pick_bits(input logic [3*COLOR_BITS-1:0] px,
                                             input logic [PLANE_W-1:0] pl);
        int idx;
        idx = int'(pl);
        return {px[2*COLOR_BITS+idx], px[COLOR_BITS+idx], px[idx]};
    endfunction

    assign tick_last = (TICK_W'(BASE_TICKS) << plane_q) - 1'b1;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        plane_d      = plane_q;
        shift_cnt_d  = shift_cnt_q;
        tick_d       = tick_q;
        rd_row_d     = rd_row_q;
        rd_col_d     = rd_col_q;
        row_out_d    = row_out_q;
        rgb0_d       = rgb0_q;
        rgb1_d       = rgb1_q;
        clk_out_d    = 1'b0;
        latch_d      = 1'b0;
        oe_d         = 1'b1;
        frame_done_d = 1'b0;

        if (state_q != IDLE && !en) begin
            // Abort: blank immediately and start the next run on a fresh frame.
            state_d = IDLE;
            row_d   = '0;
            plane_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_d     = SHIFT;
                        shift_cnt_d = '0;
                        rd_col_d    = '0;
                        rd_row_d    = row_q;
                    end
                end
                SHIFT: begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                    if (shift_cnt_q == '0) begin
                        // Address of column 0 is on the bus; data arrives next cycle.
                        clk_out_d = 1'b0;
                    end else if (shift_cnt_q[0]) begin
                        // Phase 0: data for column rd_col_q is valid now.
                        rgb0_d   = pick_bits(rd_data0, plane_q);
                        rgb1_d   = pick_bits(rd_data1, plane_q);
                        rd_col_d = (rd_col_q == COL_LAST) ? rd_col_q : rd_col_q + 1'b1;
                    end else begin
                        // Phase 1: clock the held bits into the panel.
                        clk_out_d = 1'b1;
                        if (shift_cnt_q == SHIFT_LAST) begin
                            state_d = BLANK;
                        end
                    end
                end
                BLANK: begin
                    state_d = LATCH;
                end
                LATCH: begin
                    latch_d   = 1'b1;
                    row_out_d = row_q;
                    tick_d    = '0;
                    state_d   = DISPLAY;
                end
                DISPLAY: begin
                    oe_d   = 1'b0;
                    tick_d = tick_q + 1'b1;
                    if (tick_q == tick_last) begin
                        if (plane_q == PLANE_LAST) begin
                            plane_d = '0;
                            row_d   = row_q + 1'b1;
                            if (row_q == '1) begin
                                frame_done_d = 1'b1;
                            end
                        end else begin
                            plane_d = plane_q + 1'b1;
                        end
                        state_d     = SHIFT;
                        shift_cnt_d = '0;
                        rd_col_d    = '0;
                        rd_row_d    = row_d;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge slowClk1 or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            row_q        <= '0;
            plane_q      <= '0;
            shift_cnt_q  <= '0;
            tick_q       <= '0;
            rd_row_q     <= '0;
            rd_col_q     <= '0;
            row_out_q    <= '0;
            rgb0_q       <= '0;
            rgb1_q       <= '0;
            clk_out_q    <= 1'b0;
            latch_q      <= 1'b0;
            oe_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            plane_q      <= plane_d;
            shift_cnt_q  <= shift_cnt_d;
            tick_q       <= tick_d;
            rd_row_q     <= rd_row_d;
            rd_col_q     <= rd_col_d;
            row_out_q    <= row_out_d;
            rgb0_q       <= rgb0_d;
            rgb1_q       <= rgb1_d;
            clk_out_q    <= clk_out_d;
            latch_q      <= latch_d;
            oe_q         <= oe_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rd_row      = rd_row_q;
    assign rd_col      = rd_col_q;
    assign row_out     = row_out_q;
    assign rgb0        = rgb0_q;
    assign rgb1        = rgb1_q;
    assign clk_out     = clk_out_q;
    assign latch       = latch_q;
    assign oe          = oe_q;
    assign frame_done  = frame_done_q;
    assign dbg_state_o = state_q;

endmodule
